// File: rtl/keypad_scanner_param.sv
// Parametrised ROWS x COLS active-low keypad scanner: one row driven low per dwell,
// frame-level debounce, press / auto-repeat / release events and a multi-key flag.
module keypad_scanner_param #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int KEY_W        = 4,
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE     = 3,
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_RATE  = 8,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [COLS-1:0]  col_n,
  output logic [ROWS-1:0]  row_n,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             pressed,
  output logic             released,
  output logic             multi
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_kind_t;
  typedef enum logic {ST_IDLE, ST_HELD} state_t;

  state_t           state, state_nxt;
  logic             active;
  logic [RW-1:0]    row_idx;
  logic [CNT_W-1:0] dwell_cnt;
  res_kind_t        acc_kind, cur_kind, prev_kind;
  logic [KEY_W-1:0] acc_key, cur_key, prev_key, row_key;
  logic [DW-1:0]    db_cnt, db_nxt;
  logic [CNT_W-1:0] rep_cnt, rep_nxt;
  logic [1:0]       row_hits;
  logic [CW-1:0]    row_col;
  logic             sample, frame_end, same, stable;
  logic [KEY_W-1:0] key_nxt;
  logic             kv_nxt, pressed_nxt, rel_nxt, multi_nxt;

  assign sample    = en && active && (dwell_cnt == CNT_W'(SCAN_DIV - 1));
  assign frame_end = sample && (row_idx == RW'(ROWS - 1));

  always_comb begin
    row_n = '1;
    if (active) row_n[row_idx] = 1'b0;
  end

  // Contacts on the driven row: 0, 1 or "2 or more".
  always_comb begin
    row_hits = '0;
    row_col  = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (!col_n[c]) begin
        if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
        row_col = c[CW-1:0];
      end
    end
  end

  assign row_key = KEY_W'(row_idx) * KEY_W'(COLS) + KEY_W'(row_col);

  // Fold this row into the result accumulated over the earlier rows of the frame.
  always_comb begin
    cur_kind = acc_kind;
    cur_key  = acc_key;
    if (row_hits == 2'd2) begin
      cur_kind = RES_MULTI;
    end else if (row_hits == 2'd1) begin
      if (acc_kind == RES_NONE) begin
        cur_kind = RES_SINGLE;
        cur_key  = row_key;
      end else begin
        cur_kind = RES_MULTI;
      end
    end
  end

  always_comb begin
    same   = (cur_kind == prev_kind) && ((cur_kind != RES_SINGLE) || (cur_key == prev_key));
    db_nxt = DW'(1);
    if (same) db_nxt = (db_cnt >= DW'(DEBOUNCE)) ? db_cnt : db_cnt + DW'(1);
    stable = (db_nxt >= DW'(DEBOUNCE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= 1'b0;
      row_idx   <= '0;
      dwell_cnt <= '0;
      acc_kind  <= RES_NONE;
      acc_key   <= '0;
      prev_kind <= RES_NONE;
      prev_key  <= '0;
      db_cnt    <= '0;
    end else if (!en) begin
      active    <= 1'b0;
      row_idx   <= '0;
      dwell_cnt <= '0;
      acc_kind  <= RES_NONE;
      acc_key   <= '0;
      prev_kind <= RES_NONE;
      prev_key  <= '0;
      db_cnt    <= '0;
    end else if (!active) begin
      active <= 1'b1;
    end else begin
      if (dwell_cnt == CNT_W'(SCAN_DIV - 1)) begin
        dwell_cnt <= '0;
        row_idx   <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + RW'(1);
      end else begin
        dwell_cnt <= dwell_cnt + CNT_W'(1);
      end
      if (sample) begin
        if (frame_end) begin
          acc_kind  <= RES_NONE;
          acc_key   <= '0;
          prev_kind <= cur_kind;
          prev_key  <= cur_key;
          db_cnt    <= db_nxt;
        end else begin
          acc_kind <= cur_kind;
          acc_key  <= cur_key;
        end
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    key_nxt     = key;
    kv_nxt      = 1'b0;
    rel_nxt     = 1'b0;
    pressed_nxt = pressed;
    multi_nxt   = multi;
    rep_nxt     = rep_cnt;
    if (!en) begin
      state_nxt   = ST_IDLE;
      pressed_nxt = 1'b0;
      multi_nxt   = 1'b0;
      rep_nxt     = '0;
      rel_nxt     = pressed;
    end else if (frame_end && stable) begin
      unique case (state)
        ST_IDLE: begin
          unique case (cur_kind)
            RES_SINGLE: begin
              key_nxt     = cur_key;
              kv_nxt      = 1'b1;
              pressed_nxt = 1'b1;
              multi_nxt   = 1'b0;
              rep_nxt     = CNT_W'(REPEAT_DELAY);
              state_nxt   = ST_HELD;
            end
            RES_MULTI: multi_nxt = 1'b1;
            default:   multi_nxt = 1'b0;
          endcase
        end
        ST_HELD: begin
          unique case (cur_kind)
            RES_SINGLE: begin
              multi_nxt = 1'b0;
              if (cur_key == key) begin
                // Counter parks at zero when repeat is disabled.
                if (rep_cnt != '0) begin
                  if ((rep_cnt == CNT_W'(1)) && (REPEAT_RATE != 0)) begin
                    kv_nxt  = 1'b1;
                    rep_nxt = CNT_W'(REPEAT_RATE);
                  end else begin
                    rep_nxt = rep_cnt - CNT_W'(1);
                  end
                end
              end else begin
                key_nxt = cur_key;
                kv_nxt  = 1'b1;
                rep_nxt = CNT_W'(REPEAT_DELAY);
              end
            end
            RES_MULTI: multi_nxt = 1'b1;
            default: begin
              rel_nxt     = 1'b1;
              pressed_nxt = 1'b0;
              multi_nxt   = 1'b0;
              state_nxt   = ST_IDLE;
            end
          endcase
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      key       <= '0;
      key_valid <= 1'b0;
      pressed   <= 1'b0;
      released  <= 1'b0;
      multi     <= 1'b0;
      rep_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      key       <= key_nxt;
      key_valid <= kv_nxt;
      pressed   <= pressed_nxt;
      released  <= rel_nxt;
      multi     <= multi_nxt;
      rep_cnt   <= rep_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_scanner_param.sv
// Self-checking bench: a 4x4 keypad model driven frame by frame, checked against a
// frame-level reference of debounce, press/repeat/release and multi-key behaviour.
module tb_keypad_scanner_param;

  localparam int DB = 2;
  localparam int RD = 3;
  localparam int RR = 2;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  key;
  logic        key_valid;
  logic        pressed;
  logic        released;
  logic        multi;
  logic [15:0] keys_down;

  int errors;
  int checks;

  // Reference state
  int m_prev, m_stab, m_key, m_hold;
  bit m_pressed, m_multi, e_kv, e_rel;

  keypad_scanner_param #(
    .ROWS(4), .COLS(4), .KEY_W(4), .SCAN_DIV(2), .DEBOUNCE(DB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .col_n(col_n), .row_n(row_n),
    .key(key), .key_valid(key_valid), .pressed(pressed),
    .released(released), .multi(multi)
  );

  always #5 clk = ~clk;

  // Physical keypad: a closed switch pulls its column low only while its row is driven.
  always_comb begin
    col_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_down[r*4 + c] && !row_n[r]) col_n[c] = 1'b0;
  end

  function automatic logic [15:0] kbit(input int k);
    logic [15:0] v;
    v = 16'd1;
    return v << k;
  endfunction

  // -1 = no key, -2 = several keys, otherwise the single key index.
  function automatic int frame_result(input logic [15:0] ks);
    int n, idx;
    n = 0; idx = -1;
    for (int i = 0; i < 16; i++) if (ks[i]) begin n++; idx = i; end
    if (n == 0) return -1;
    if (n > 1) return -2;
    return idx;
  endfunction

  task automatic model_reset(input bit keep_key);
    m_prev = -1; m_stab = 0; m_hold = 0;
    m_pressed = 0; m_multi = 0; e_kv = 0; e_rel = 0;
    if (!keep_key) m_key = 0;
  endtask

  task automatic model_frame(input logic [15:0] ks);
    int r;
    r = frame_result(ks);
    m_stab = (r == m_prev) ? ((m_stab < DB) ? m_stab + 1 : DB) : 1;
    m_prev = r;
    e_kv = 0; e_rel = 0;
    if (m_stab >= DB) begin
      if (r == -2) m_multi = 1;
      else if (r == -1) begin
        m_multi = 0;
        if (m_pressed) begin e_rel = 1; m_pressed = 0; end
      end else begin
        m_multi = 0;
        if (!m_pressed || r != m_key) begin
          m_pressed = 1; m_key = r; m_hold = 0; e_kv = 1;
        end else begin
          m_hold++;
          if (m_hold >= RD && ((m_hold - RD) % RR) == 0) e_kv = 1;
        end
      end
    end
  endtask

  // One full scan frame, entered #1 after a frame boundary edge.
  task automatic frame_step(input logic [15:0] ks);
    logic [3:0] er;
    keys_down = ks;
    for (int s = 1; s <= 8; s++) begin
      @(posedge clk); #1;
      er = '1;
      er[(s % 8) / 2] = 1'b0;
      checks++;
      if (row_n !== er) begin
        errors++; $display("FAIL row_n step %0d: got %b exp %b", s, row_n, er);
      end
      if (s < 8) begin
        checks++;
        if ({key_valid, released} !== 2'b00) begin
          errors++; $display("FAIL mid_frame_pulse step %0d: kv/rel got %b exp 00", s, {key_valid, released});
        end
      end else begin
        model_frame(ks);
        checks++;
        if (key_valid !== e_kv) begin
          errors++; $display("FAIL key_valid: got %b exp %b", key_valid, e_kv);
        end
        checks++;
        if (released !== e_rel) begin
          errors++; $display("FAIL released: got %b exp %b", released, e_rel);
        end
        checks++;
        if (pressed !== m_pressed) begin
          errors++; $display("FAIL pressed: got %b exp %b", pressed, m_pressed);
        end
        checks++;
        if (multi !== m_multi) begin
          errors++; $display("FAIL multi: got %b exp %b", multi, m_multi);
        end
        checks++;
        if (key !== 4'(m_key)) begin
          errors++; $display("FAIL key: got %0d exp %0d", key, m_key);
        end
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({row_n, key, key_valid, pressed, released, multi} !== {4'hF, 4'h0, 4'b0000}) begin
      errors++;
      $display("FAIL %s: row_n=%b key=%0d kv=%b pr=%b rel=%b multi=%b exp row_n=1111 others 0",
               tag, row_n, key, key_valid, pressed, released, multi);
    end
  endtask

  // Reset, then release so the next edge starts row 0.
  task automatic start_scan();
    rst_n = 0; en = 1;
    #1;
    check_reset_values("reset_async");
    @(posedge clk); @(posedge clk); #1;
    check_reset_values("reset_held");
    model_reset(0);
    rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (row_n !== 4'b1110) begin
      errors++; $display("FAIL scan_start row_n: got %b exp 1110", row_n);
    end
  endtask

  task automatic test_reset();
    keys_down = '0;
    start_scan();
    for (int f = 0; f < 2; f++) frame_step('0);
  endtask

  task automatic test_press_release();
    start_scan();
    for (int f = 1; f <= 5; f++) frame_step((f <= 3) ? kbit(6) : 16'd0);
    checks++;
    if ({key, pressed} !== {4'd6, 1'b0}) begin
      errors++; $display("FAIL press_release_end: key=%0d pressed=%b exp key=6 pressed=0", key, pressed);
    end
  endtask

  task automatic test_hold_repeat();
    logic [15:0] mask;
    start_scan();
    mask = '0;
    for (int f = 1; f <= 12; f++) begin
      frame_step(kbit(6));
      if (key_valid === 1'b1) mask[f] = 1'b1;
    end
    checks++;
    if (mask !== 16'h0AA4) begin
      errors++; $display("FAIL repeat_frames: got mask %h exp 0aa4", mask);
    end
    frame_step('0);
    frame_step('0);
  endtask

  task automatic test_chatter();
    int kv_seen;
    kv_seen = 0;
    for (int f = 0; f < 6; f++) begin
      frame_step((f % 2 == 0) ? kbit(9) : 16'd0);
      if (key_valid === 1'b1) kv_seen++;
      checks++;
      if (pressed !== 1'b0) begin
        errors++; $display("FAIL chatter_pressed frame %0d: got %b exp 0", f, pressed);
      end
    end
    checks++;
    if (kv_seen != 0) begin
      errors++; $display("FAIL chatter_kv: got %0d events exp 0", kv_seen);
    end
  endtask

  task automatic test_multi();
    start_scan();
    for (int f = 1; f <= 3; f++) frame_step(kbit(0) | kbit(15));
    checks++;
    if ({multi, pressed} !== 2'b10) begin
      errors++; $display("FAIL multi_set: multi/pressed got %b exp 10", {multi, pressed});
    end
    frame_step(kbit(0));
    frame_step(kbit(0));
    checks++;
    if ({key_valid, key, multi} !== {1'b1, 4'd0, 1'b0}) begin
      errors++; $display("FAIL multi_to_single: kv=%b key=%0d multi=%b exp kv=1 key=0 multi=0",
                         key_valid, key, multi);
    end
  endtask

  task automatic test_en_drop();
    start_scan();
    for (int f = 0; f < 3; f++) frame_step(kbit(3));
    en = 0;
    @(posedge clk); #1;
    checks++;
    if ({row_n, released, pressed, multi, key_valid, key} !== {4'hF, 4'b1000, 4'd3}) begin
      errors++; $display("FAIL en_drop: row_n=%b rel=%b pr=%b multi=%b kv=%b key=%0d exp 1111 1 0 0 0 3",
                         row_n, released, pressed, multi, key_valid, key);
    end
    @(posedge clk); #1;
    checks++;
    if ({row_n, released} !== {4'hF, 1'b0}) begin
      errors++; $display("FAIL en_drop_hold: row_n=%b rel=%b exp 1111 0", row_n, released);
    end
    model_reset(1);
    en = 1;
    @(posedge clk); #1;
    checks++;
    if (row_n !== 4'b1110) begin
      errors++; $display("FAIL en_restart row_n: got %b exp 1110", row_n);
    end
    for (int f = 0; f < 3; f++) frame_step(kbit(3));
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    rst_n = 0;
    #1;
    check_reset_values("reset_mid_frame");
  endtask

  task automatic test_random();
    logic [15:0] ks;
    int sel;
    start_scan();
    ks = '0;
    for (int f = 0; f < 80; f++) begin
      sel = int'($urandom_range(0, 9));
      if (sel >= 4 && sel <= 5) ks = '0;
      else if (sel >= 6 && sel <= 8) ks = kbit(int'($urandom_range(0, 15)));
      else if (sel == 9) ks = kbit(int'($urandom_range(0, 15))) | kbit(int'($urandom_range(0, 15)));
      frame_step(ks);
      checks++;
      if (key_valid && released) begin
        errors++; $display("FAIL pulse_overlap frame %0d: kv=1 rel=1 exp not both", f);
      end
    end
  endtask

  initial begin
    clk = 0; rst_n = 1; en = 1; keys_down = '0;
    errors = 0; checks = 0;
    model_reset(0);
    #2;
    test_reset();
    test_press_release();
    test_hold_repeat();
    test_chatter();
    test_multi();
    test_en_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
